// File: rtl/ram_access_arbiter_if.sv
// Master-side request/response bundle for the two-master RAM access arbiter.
// The arbiter takes the slave modport; request generators take the master modport.
interface ram_access_arbiter_if #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned ADDR_LINE = 8
);
  logic                 m0_wr_valid;
  logic                 m1_wr_valid;
  logic                 m0_wr_last;
  logic                 m1_wr_last;
  logic [ADDR_LINE-1:0] m0_wr_addr;
  logic [ADDR_LINE-1:0] m1_wr_addr;
  logic [RAM_WIDTH-1:0] m0_wr_data;
  logic [RAM_WIDTH-1:0] m1_wr_data;
  logic                 m0_wr_ready;
  logic                 m1_wr_ready;

  logic                 m0_rd_valid;
  logic                 m1_rd_valid;
  logic                 m0_rd_last;
  logic                 m1_rd_last;
  logic [ADDR_LINE-1:0] m0_rd_addr;
  logic [ADDR_LINE-1:0] m1_rd_addr;
  logic                 m0_rd_ready;
  logic                 m1_rd_ready;

  logic                 m0_rsp_valid;
  logic                 m1_rsp_valid;
  logic [RAM_WIDTH-1:0] m0_rsp_data;
  logic [RAM_WIDTH-1:0] m1_rsp_data;

  modport slave (
    input  m0_wr_valid, m1_wr_valid, m0_wr_last, m1_wr_last,
    input  m0_wr_addr, m1_wr_addr, m0_wr_data, m1_wr_data,
    output m0_wr_ready, m1_wr_ready,
    input  m0_rd_valid, m1_rd_valid, m0_rd_last, m1_rd_last,
    input  m0_rd_addr, m1_rd_addr,
    output m0_rd_ready, m1_rd_ready,
    output m0_rsp_valid, m1_rsp_valid, m0_rsp_data, m1_rsp_data
  );

  modport master (
    output m0_wr_valid, m1_wr_valid, m0_wr_last, m1_wr_last,
    output m0_wr_addr, m1_wr_addr, m0_wr_data, m1_wr_data,
    input  m0_wr_ready, m1_wr_ready,
    output m0_rd_valid, m1_rd_valid, m0_rd_last, m1_rd_last,
    output m0_rd_addr, m1_rd_addr,
    input  m0_rd_ready, m1_rd_ready,
    input  m0_rsp_valid, m1_rsp_valid, m0_rsp_data, m1_rsp_data
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Two-master access controller for one dual-port RAM: independent round-robin
// write and read arbiters with burst locking, plus one-cycle read-return tagging.
module ram_access_arbiter #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned ADDR_LINE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_arbiter_if.slave  bus,
  output logic                 ram_wr_en,
  output logic [ADDR_LINE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_wr_data,
  output logic                 ram_rd_en,
  output logic [ADDR_LINE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_e;

  arb_state_e wr_state;
  arb_state_e rd_state;
  logic       wr_lg;
  logic       rd_lg;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;
  logic       rsp_pend;
  logic       rsp_id;
  logic       rsp_live;

  // One-hot grant {m1, m0}; a locked port serves only its owner.
  function automatic logic [1:0] arb_grant(input arb_state_e st, input logic lg,
                                           input logic v0, input logic v1);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      ARB_LOCK0: g = {1'b0, v0};
      ARB_LOCK1: g = {v1, 1'b0};
      default: begin
        if (v0 && v1) g = lg ? 2'b01 : 2'b10;
        else          g = {v1, v0};
      end
    endcase
    return g;
  endfunction

  // A grant without last locks the port to that master; a grant with last frees it.
  function automatic arb_state_e arb_next(input arb_state_e st, input logic [1:0] g,
                                          input logic l0, input logic l1);
    arb_state_e n;
    n = st;
    if (g[0])      n = l0 ? ARB_IDLE : ARB_LOCK0;
    else if (g[1]) n = l1 ? ARB_IDLE : ARB_LOCK1;
    return n;
  endfunction

  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 2'b00;
    if (!rst) begin
      wr_gnt = arb_grant(wr_state, wr_lg, bus.m0_wr_valid, bus.m1_wr_valid);
      rd_gnt = arb_grant(rd_state, rd_lg, bus.m0_rd_valid, bus.m1_rd_valid);
    end
  end

  always_comb begin
    bus.m0_wr_ready = wr_gnt[0];
    bus.m1_wr_ready = wr_gnt[1];
    ram_wr_en       = |wr_gnt;
    ram_wr_addr     = '0;
    ram_wr_data     = '0;
    if (wr_gnt[0]) begin
      ram_wr_addr = bus.m0_wr_addr;
      ram_wr_data = bus.m0_wr_data;
    end else if (wr_gnt[1]) begin
      ram_wr_addr = bus.m1_wr_addr;
      ram_wr_data = bus.m1_wr_data;
    end
  end

  always_comb begin
    bus.m0_rd_ready = rd_gnt[0];
    bus.m1_rd_ready = rd_gnt[1];
    ram_rd_en       = |rd_gnt;
    ram_rd_addr     = '0;
    if (rd_gnt[0])      ram_rd_addr = bus.m0_rd_addr;
    else if (rd_gnt[1]) ram_rd_addr = bus.m1_rd_addr;
  end

  // Read data is steered to the tagged master and forced to zero elsewhere.
  always_comb begin
    rsp_live         = rsp_pend & ~rst;
    bus.m0_rsp_valid = rsp_live & ~rsp_id;
    bus.m1_rsp_valid = rsp_live & rsp_id;
    bus.m0_rsp_data  = (rsp_live && !rsp_id) ? ram_rd_data : '0;
    bus.m1_rsp_data  = (rsp_live &&  rsp_id) ? ram_rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= ARB_IDLE;
      rd_state <= ARB_IDLE;
      wr_lg    <= 1'b1;
      rd_lg    <= 1'b1;
      rsp_pend <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      wr_state <= arb_next(wr_state, wr_gnt, bus.m0_wr_last, bus.m1_wr_last);
      rd_state <= arb_next(rd_state, rd_gnt, bus.m0_rd_last, bus.m1_rd_last);
      if (|wr_gnt) wr_lg <= wr_gnt[1];
      if (|rd_gnt) begin
        rd_lg  <= rd_gnt[1];
        rsp_id <= rd_gnt[1];
      end
      rsp_pend <= |rd_gnt;
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: directed scenarios plus a
// randomized run compared against a behavioural arbitration/memory model.
module tb_ram_access_arbiter;
  localparam int unsigned RW = 16;
  localparam int unsigned AL = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_access_arbiter_if #(.RAM_WIDTH(RW), .ADDR_LINE(AL)) bus ();

  logic          ram_wr_en;
  logic [AL-1:0] ram_wr_addr;
  logic [RW-1:0] ram_wr_data;
  logic          ram_rd_en;
  logic [AL-1:0] ram_rd_addr;
  logic [RW-1:0] ram_rd_data;

  ram_access_arbiter #(.RAM_WIDTH(RW), .ADDR_LINE(AL)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // Dual-port RAM stand-in: registered read, read-before-write on collision.
  logic [RW-1:0] ram_mem [256];
  logic [RW-1:0] ram_rd_q;
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_q <= ram_mem[ram_rd_addr];
  end
  assign ram_rd_data = ram_rd_q;

  // Reference model: owner -1 means unlocked; lastw is the last master served.
  int            w_owner = -1, w_lastw = 1, r_owner = -1, r_lastw = 1;
  logic [RW-1:0] model_mem [256];
  logic          exp_rv [2];
  logic [RW-1:0] exp_rd [2];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic int exp_gnt(input int owner, input int lastw,
                                 input logic v0, input logic v1, input logic r);
    if (r) return -1;
    if (owner == 0) return v0 ? 0 : -1;
    if (owner == 1) return v1 ? 1 : -1;
    if (v0 && v1) return 1 - lastw;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_update();
    int gw, gr;
    logic lst;
    gw = exp_gnt(w_owner, w_lastw, bus.m0_wr_valid, bus.m1_wr_valid, rst);
    gr = exp_gnt(r_owner, r_lastw, bus.m0_rd_valid, bus.m1_rd_valid, rst);
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (rst) begin
      w_owner = -1; r_owner = -1; w_lastw = 1; r_lastw = 1;
    end else begin
      if (gr >= 0) begin
        exp_rv[gr] = 1'b1;
        exp_rd[gr] = model_mem[(gr == 0) ? bus.m0_rd_addr : bus.m1_rd_addr];
        lst = (gr == 0) ? bus.m0_rd_last : bus.m1_rd_last;
        r_lastw = gr;
        r_owner = lst ? -1 : gr;
      end
      if (gw >= 0) begin
        if (gw == 0) model_mem[bus.m0_wr_addr] = bus.m0_wr_data;
        else         model_mem[bus.m1_wr_addr] = bus.m1_wr_data;
        lst = (gw == 0) ? bus.m0_wr_last : bus.m1_wr_last;
        w_lastw = gw;
        w_owner = lst ? -1 : gw;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.m0_wr_valid = 1'b0; bus.m1_wr_valid = 1'b0;
    bus.m0_wr_last  = 1'b0; bus.m1_wr_last  = 1'b0;
    bus.m0_wr_addr  = '0;   bus.m1_wr_addr  = '0;
    bus.m0_wr_data  = '0;   bus.m1_wr_data  = '0;
    bus.m0_rd_valid = 1'b0; bus.m1_rd_valid = 1'b0;
    bus.m0_rd_last  = 1'b0; bus.m1_rd_last  = 1'b0;
    bus.m0_rd_addr  = '0;   bus.m1_rd_addr  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.m0_wr_valid = 1'b1; bus.m1_wr_valid = 1'b1;
    bus.m0_rd_valid = 1'b1; bus.m1_rd_valid = 1'b1;
    bus.m0_wr_addr = 8'h33; bus.m0_wr_data = 16'hBEEF; bus.m1_rd_addr = 8'h44;
    next_cycle();
    #1;
    n_checks++;
    if ({bus.m1_wr_ready, bus.m0_wr_ready, bus.m1_rd_ready, bus.m0_rd_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ready got=%b exp=0000",
               {bus.m1_wr_ready, bus.m0_wr_ready, bus.m1_rd_ready, bus.m0_rd_ready});
    end
    n_checks++;
    if ({ram_wr_en, ram_rd_en} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ram_en got=%b exp=00", {ram_wr_en, ram_rd_en});
    end
    n_checks++;
    if ({ram_wr_addr, ram_wr_data, ram_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_ram_bus got=%h/%h/%h exp=0", ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    n_checks++;
    if ({bus.m0_rsp_valid, bus.m1_rsp_valid, bus.m0_rsp_data, bus.m1_rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp got=%b%b %h %h exp=0", bus.m0_rsp_valid, bus.m1_rsp_valid,
               bus.m0_rsp_data, bus.m1_rsp_data);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic preload();
    for (int a = 0; a < 256; a++) begin
      bus.m0_wr_valid = 1'b1; bus.m0_wr_last = 1'b1;
      bus.m0_wr_addr = AL'(a); bus.m0_wr_data = RW'($urandom);
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_single_write_read();
    bus.m0_wr_valid = 1'b1; bus.m0_wr_last = 1'b1;
    bus.m0_wr_addr = 8'h05; bus.m0_wr_data = 16'h1234;
    #1;
    n_checks++;
    if ({bus.m1_wr_ready, bus.m0_wr_ready, ram_wr_en, ram_wr_addr, ram_wr_data} !== {2'b01, 1'b1, 8'h05, 16'h1234}) begin
      n_fail++;
      $display("FAIL swr_write got=%b%b en=%b %h %h exp=01 en=1 05 1234", bus.m1_wr_ready,
               bus.m0_wr_ready, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    next_cycle();
    idle_inputs();
    bus.m0_rd_valid = 1'b1; bus.m0_rd_last = 1'b1; bus.m0_rd_addr = 8'h05;
    #1;
    n_checks++;
    if ({bus.m0_rd_ready, ram_rd_en, ram_rd_addr, bus.m1_rsp_valid, bus.m1_rsp_data} !== {1'b1, 1'b1, 8'h05, 17'h0}) begin
      n_fail++;
      $display("FAIL swr_read_req got=rdy%b en%b %h m1rsp=%b %h exp=rdy1 en1 05 m1rsp=0 0",
               bus.m0_rd_ready, ram_rd_en, ram_rd_addr, bus.m1_rsp_valid, bus.m1_rsp_data);
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.m0_rsp_valid, bus.m0_rsp_data} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL swr_m0_rsp got=%b %h exp=1 1234", bus.m0_rsp_valid, bus.m0_rsp_data);
    end
    n_checks++;
    if ({bus.m1_rsp_valid, bus.m1_rsp_data} !== 17'h0) begin
      n_fail++;
      $display("FAIL swr_m1_rsp got=%b %h exp=0 0", bus.m1_rsp_valid, bus.m1_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.m0_wr_valid = 1'b1; bus.m1_wr_valid = 1'b1;
      bus.m0_wr_last  = 1'b1; bus.m1_wr_last  = 1'b1;
      bus.m0_wr_addr = 8'h20; bus.m1_wr_addr = 8'h21;
      bus.m0_wr_data = RW'(16'hA000 + i); bus.m1_wr_data = RW'(16'hB000 + i);
      #1;
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if ({bus.m1_wr_ready, bus.m0_wr_ready} !== exp) begin
        n_fail++;
        $display("FAIL rr_tie cycle=%0d got=%b exp=%b", i, {bus.m1_wr_ready, bus.m0_wr_ready}, exp);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_burst_lock();
    logic [4:0] m1v, m1l, m0v, e1, e0;
    m1v = 5'b01011; m1l = 5'b01000; m0v = 5'b11110;
    e1  = 5'b01011; e0  = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      bus.m1_wr_valid = m1v[i]; bus.m1_wr_last = m1l[i];
      bus.m1_wr_addr = AL'(8'h40 + i); bus.m1_wr_data = RW'(16'h1000 + i);
      bus.m0_wr_valid = m0v[i]; bus.m0_wr_last = 1'b1;
      bus.m0_wr_addr = 8'h50; bus.m0_wr_data = 16'h0BAD;
      #1;
      n_checks++;
      if ({bus.m1_wr_ready, bus.m0_wr_ready, ram_wr_en} !== {e1[i], e0[i], e1[i] | e0[i]}) begin
        n_fail++;
        $display("FAIL burst_lock cycle=%0d got=%b%b en=%b exp=%b%b en=%b", i, bus.m1_wr_ready,
                 bus.m0_wr_ready, ram_wr_en, e1[i], e0[i], e1[i] | e0[i]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_interleaved_reads();
    logic [1:0]  eg;
    logic [33:0] er;
    bus.m0_wr_valid = 1'b1; bus.m0_wr_last = 1'b1; bus.m0_wr_addr = 8'h01; bus.m0_wr_data = 16'hAAAA;
    next_cycle();
    idle_inputs();
    bus.m1_wr_valid = 1'b1; bus.m1_wr_last = 1'b1; bus.m1_wr_addr = 8'h02; bus.m1_wr_data = 16'h5555;
    next_cycle();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.m0_rd_valid = 1'b1; bus.m1_rd_valid = 1'b1;
        bus.m0_rd_last  = 1'b1; bus.m1_rd_last  = 1'b1;
        bus.m0_rd_addr = 8'h01; bus.m1_rd_addr = 8'h02;
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 4) begin
        eg = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++;
        if ({bus.m1_rd_ready, bus.m0_rd_ready} !== eg) begin
          n_fail++;
          $display("FAIL ilv_grant cycle=%0d got=%b exp=%b", i, {bus.m1_rd_ready, bus.m0_rd_ready}, eg);
        end
      end
      if (i > 0) begin
        er = ((i - 1) % 2 == 0) ? {1'b1, 16'hAAAA, 1'b0, 16'h0} : {1'b0, 16'h0, 1'b1, 16'h5555};
        n_checks++;
        if ({bus.m0_rsp_valid, bus.m0_rsp_data, bus.m1_rsp_valid, bus.m1_rsp_data} !== er) begin
          n_fail++;
          $display("FAIL ilv_rsp cycle=%0d got=%b %h %b %h exp=%b %h %b %h", i, bus.m0_rsp_valid,
                   bus.m0_rsp_data, bus.m1_rsp_valid, bus.m1_rsp_data, er[33], er[32:17], er[16], er[15:0]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_same_addr();
    bus.m0_wr_valid = 1'b1; bus.m0_wr_last = 1'b1; bus.m0_wr_addr = 8'h07; bus.m0_wr_data = 16'h0001;
    next_cycle();
    bus.m0_wr_data = 16'h00FF;
    bus.m1_rd_valid = 1'b1; bus.m1_rd_last = 1'b1; bus.m1_rd_addr = 8'h07;
    #1;
    n_checks++;
    if ({bus.m0_wr_ready, bus.m1_rd_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL rw_same_grant got=%b exp=11", {bus.m0_wr_ready, bus.m1_rd_ready});
    end
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.m1_rsp_valid, bus.m1_rsp_data, bus.m0_rsp_valid} !== {1'b1, 16'h0001, 1'b0}) begin
      n_fail++;
      $display("FAIL rw_same_old got=%b %h m0v=%b exp=1 0001 m0v=0", bus.m1_rsp_valid,
               bus.m1_rsp_data, bus.m0_rsp_valid);
    end
    next_cycle();
    bus.m0_rd_valid = 1'b1; bus.m0_rd_last = 1'b1; bus.m0_rd_addr = 8'h07;
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.m0_rsp_valid, bus.m0_rsp_data} !== {1'b1, 16'h00FF}) begin
      n_fail++;
      $display("FAIL rw_same_new got=%b %h exp=1 00ff", bus.m0_rsp_valid, bus.m0_rsp_data);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [RW-1:0] exp3;
    bus.m0_rd_valid = 1'b1; bus.m0_rd_last = 1'b0; bus.m0_rd_addr = 8'h03;
    bus.m1_wr_valid = 1'b1; bus.m1_wr_last = 1'b0; bus.m1_wr_addr = 8'h60; bus.m1_wr_data = 16'h7777;
    #1;
    n_checks++;
    if ({bus.m0_rd_ready, bus.m1_wr_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_start got=%b exp=11", {bus.m0_rd_ready, bus.m1_wr_ready});
    end
    next_cycle();
    rst = 1'b1;
    bus.m0_rd_addr = 8'h04; bus.m1_rd_valid = 1'b1; bus.m0_wr_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.m0_rsp_valid, bus.m1_rsp_valid, bus.m0_rd_ready, bus.m1_rd_ready,
         bus.m0_wr_ready, bus.m1_wr_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_during got=rsp%b%b rd%b%b wr%b%b exp=all0", bus.m0_rsp_valid,
               bus.m1_rsp_valid, bus.m0_rd_ready, bus.m1_rd_ready, bus.m0_wr_ready, bus.m1_wr_ready);
    end
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    bus.m0_wr_valid = 1'b1; bus.m1_wr_valid = 1'b1; bus.m0_wr_last = 1'b1; bus.m1_wr_last = 1'b1;
    bus.m0_wr_addr = 8'h61; bus.m1_wr_addr = 8'h62; bus.m0_wr_data = 16'h1111; bus.m1_wr_data = 16'h2222;
    bus.m0_rd_valid = 1'b1; bus.m1_rd_valid = 1'b1; bus.m0_rd_last = 1'b1; bus.m1_rd_last = 1'b1;
    bus.m0_rd_addr = 8'h03; bus.m1_rd_addr = 8'h02;
    #1;
    n_checks++;
    if ({bus.m0_rsp_valid, bus.m1_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstmid_no_rsp got=%b exp=00", {bus.m0_rsp_valid, bus.m1_rsp_valid});
    end
    n_checks++;
    if ({bus.m1_wr_ready, bus.m0_wr_ready, bus.m1_rd_ready, bus.m0_rd_ready} !== 4'b0101) begin
      n_fail++;
      $display("FAIL rstmid_tie got=wr%b%b rd%b%b exp=wr01 rd01", bus.m1_wr_ready,
               bus.m0_wr_ready, bus.m1_rd_ready, bus.m0_rd_ready);
    end
    exp3 = model_mem[3];
    next_cycle();
    idle_inputs();
    #1;
    n_checks++;
    if ({bus.m0_rsp_valid, bus.m0_rsp_data} !== {1'b1, exp3}) begin
      n_fail++;
      $display("FAIL rstmid_post_rsp got=%b %h exp=1 %h", bus.m0_rsp_valid, bus.m0_rsp_data, exp3);
    end
    next_cycle();
  endtask

  task automatic test_random();
    int gw, gr;
    logic [1:0] ew, er;
    logic [AL+RW:0] ewb;
    logic [AL:0] erb;
    logic ev0, ev1;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.m0_wr_valid = ($urandom_range(0, 9) < 7); bus.m1_wr_valid = ($urandom_range(0, 9) < 7);
      bus.m0_rd_valid = ($urandom_range(0, 9) < 7); bus.m1_rd_valid = ($urandom_range(0, 9) < 7);
      bus.m0_wr_last = ($urandom_range(0, 2) == 0); bus.m1_wr_last = ($urandom_range(0, 2) == 0);
      bus.m0_rd_last = ($urandom_range(0, 2) == 0); bus.m1_rd_last = ($urandom_range(0, 2) == 0);
      bus.m0_wr_addr = AL'($urandom_range(0, 15)); bus.m1_wr_addr = AL'($urandom_range(0, 15));
      bus.m0_rd_addr = AL'($urandom_range(0, 15)); bus.m1_rd_addr = AL'($urandom_range(0, 15));
      bus.m0_wr_data = RW'($urandom); bus.m1_wr_data = RW'($urandom);
      #1;
      gw = exp_gnt(w_owner, w_lastw, bus.m0_wr_valid, bus.m1_wr_valid, rst);
      gr = exp_gnt(r_owner, r_lastw, bus.m0_rd_valid, bus.m1_rd_valid, rst);
      ew = (gw == 0) ? 2'b01 : (gw == 1) ? 2'b10 : 2'b00;
      er = (gr == 0) ? 2'b01 : (gr == 1) ? 2'b10 : 2'b00;
      ewb = '0;
      if (gw == 0) ewb = {1'b1, bus.m0_wr_addr, bus.m0_wr_data};
      if (gw == 1) ewb = {1'b1, bus.m1_wr_addr, bus.m1_wr_data};
      erb = '0;
      if (gr == 0) erb = {1'b1, bus.m0_rd_addr};
      if (gr == 1) erb = {1'b1, bus.m1_rd_addr};
      ev0 = !rst && exp_rv[0];
      ev1 = !rst && exp_rv[1];
      n_checks++;
      if ({bus.m1_wr_ready, bus.m0_wr_ready, ram_wr_en, ram_wr_addr, ram_wr_data} !== {ew, ewb}) begin
        n_fail++;
        $display("FAIL rand_wr n=%0d got=%b%b %b %h %h exp=%b %b %h %h", n, bus.m1_wr_ready,
                 bus.m0_wr_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ew, ewb[AL+RW],
                 ewb[AL+RW-1:RW], ewb[RW-1:0]);
      end
      n_checks++;
      if ({bus.m1_rd_ready, bus.m0_rd_ready, ram_rd_en, ram_rd_addr} !== {er, erb}) begin
        n_fail++;
        $display("FAIL rand_rd n=%0d got=%b%b %b %h exp=%b %b %h", n, bus.m1_rd_ready,
                 bus.m0_rd_ready, ram_rd_en, ram_rd_addr, er, erb[AL], erb[AL-1:0]);
      end
      n_checks++;
      if ({bus.m0_rsp_valid, bus.m0_rsp_data} !== {ev0, ev0 ? exp_rd[0] : 16'h0}) begin
        n_fail++;
        $display("FAIL rand_rsp0 n=%0d got=%b %h exp=%b %h", n, bus.m0_rsp_valid, bus.m0_rsp_data,
                 ev0, ev0 ? exp_rd[0] : 16'h0);
      end
      n_checks++;
      if ({bus.m1_rsp_valid, bus.m1_rsp_data} !== {ev1, ev1 ? exp_rd[1] : 16'h0}) begin
        n_fail++;
        $display("FAIL rand_rsp1 n=%0d got=%b %h exp=%b %h", n, bus.m1_rsp_valid, bus.m1_rsp_data,
                 ev1, ev1 ? exp_rd[1] : 16'h0);
      end
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    test_reset();
    preload();
    test_single_write_read();
    test_round_robin();
    test_burst_lock();
    test_interleaved_reads();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
